// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the dot-product sequencer (mac_dot_seq) and its
// valid-pipe helper (mac_vld_pipe).
//   mac_state_e  : sequencer states IDLE / ISSUE / DRAIN / DONE
//   MAC_PIPE_LAT : cycles from an SRAM read strobe to the matching
//                  accumulate enable (SRAM read, operand reg, product reg)
//   PSUM_W       : MAC accumulator width
//   OPND_W       : MAC operand width
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_e;

    localparam int MAC_PIPE_LAT = 3;
    localparam int PSUM_W       = 65;
    localparam int OPND_W       = 32;

endpackage : mac_pkg

// File: rtl/mac_vld_pipe.sv
// ---------------------------------------------------------------------------
// mac_vld_pipe
// Valid-bit shift register that tracks issued SRAM reads through the MAC
// pipeline so that the accumulate enable lines up with the product register.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   vld_in       : read strobe entering the pipe this cycle
//   flush        : synchronous clear of every stage (command abort)
//   vld_out      : last stage, drives the MAC accumulate enable
//   pipe_empty   : no valid entry behind the output stage, i.e. the pipe is
//                  empty once the output stage (if any) retires this cycle
// ---------------------------------------------------------------------------
module mac_vld_pipe
    import mac_pkg::*;
#(
    parameter int DEPTH = MAC_PIPE_LAT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vld_in,
    input  logic flush,
    output logic vld_out,
    output logic pipe_empty
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    // Next-state of the shift register: shift in the read strobe or flush.
    always_comb begin
        vld_d = vld_q;
        if (flush) begin
            vld_d = {DEPTH{1'b0}};
        end else begin
            vld_d = {vld_q[DEPTH-2:0], vld_in};
        end
    end

    // Valid-pipe state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= {DEPTH{1'b0}};
        end else begin
            vld_q <= vld_d;
        end
    end

    assign vld_out    = vld_q[DEPTH-1];
    // Looking only behind the output stage lets the sequencer leave DRAIN in
    // the same cycle the final accumulate happens, so DONE sees the full sum.
    assign pipe_empty = ~(|vld_q[DEPTH-2:0]);

endmodule : mac_vld_pipe

// File: rtl/mac_dot_seq.sv
// ---------------------------------------------------------------------------
// mac_dot_seq
// Sequences one dot product of two length-N 32-bit vectors through an
// external 2-stage MAC (operand reg, product reg, 65-bit accumulator).
// Operands come from two synchronous SRAM ports with 1-cycle read latency.
// Optional build macro: MAC_DOT_SEQ_PERF_EN adds stall_cnt / cmd_cycles.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   start, base_a, base_b,  command strobe (IDLE only), start addresses,
//   len                     element count N
//   abort                   abandon the running command
//   mem_ready               both SRAM ports accept a read this cycle
//   rd_en, rd_addr_a/b      SRAM read strobe and addresses
//   rd_data_a/b             SRAM read data, valid cycle after rd_en
//   mac_a, mac_b            MAC operands (pass-through of read data)
//   mac_clear, mac_next     MAC accumulator clear / accumulate enable
//   mac_psum                MAC accumulator value
//   busy, done, result      status, completion pulse, captured sum
//   stall_cnt, cmd_cycles   (MAC_DOT_SEQ_PERF_EN only) perf counters
// ---------------------------------------------------------------------------
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int AW    = 10,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [AW-1:0]     base_a,
    input  logic [AW-1:0]     base_b,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              mem_ready,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr_a,
    output logic [AW-1:0]     rd_addr_b,
    input  logic [OPND_W-1:0] rd_data_a,
    input  logic [OPND_W-1:0] rd_data_b,
    output logic [OPND_W-1:0] mac_a,
    output logic [OPND_W-1:0] mac_b,
    output logic              mac_clear,
    output logic              mac_next,
    input  logic [PSUM_W-1:0] mac_psum,
    output logic              busy,
    output logic              done,
    output logic [PSUM_W-1:0] result
`ifdef MAC_DOT_SEQ_PERF_EN
    ,
    output logic [LEN_W+7:0]  stall_cnt,
    output logic [31:0]       cmd_cycles
`endif
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [AW-1:0]    ADDR_ONE = AW'(1);

    mac_state_e          state_q, state_d;
    logic [AW-1:0]       addr_a_q, addr_a_d;
    logic [AW-1:0]       addr_b_q, addr_b_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [PSUM_W-1:0]   result_q, result_d;
    logic                flush;
    logic                vld_out;
    logic                pipe_empty;

    // Sequencer next-state, address/count update and control strobes.
    always_comb begin
        state_d   = state_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        rem_d     = rem_q;
        result_d  = result_q;
        rd_en     = 1'b0;
        mac_clear = 1'b0;
        done      = 1'b0;
        flush     = 1'b0;
        case (state_q)
            IDLE: begin
                // abort has no meaning here; start always wins.
                if (start) begin
                    mac_clear = 1'b1;
                    addr_a_d  = base_a;
                    addr_b_d  = base_b;
                    rem_d     = len;
                    if (len == LEN_ZERO) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (mem_ready) begin
                    rd_en    = 1'b1;
                    // Addresses wrap naturally at 2^AW.
                    addr_a_d = addr_a_q + ADDR_ONE;
                    addr_b_d = addr_b_q + ADDR_ONE;
                    rem_d    = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    // Stall: a bubble enters the valid pipe.
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (pipe_empty) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else begin
                    done     = 1'b1;
                    result_d = mac_psum;
                    state_d  = IDLE;
                end
            end
            default: begin
                flush   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_a_q <= {AW{1'b0}};
            addr_b_q <= {AW{1'b0}};
            rem_q    <= LEN_ZERO;
            result_q <= {PSUM_W{1'b0}};
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    mac_vld_pipe #(
        .DEPTH (MAC_PIPE_LAT)
    ) u_vld_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .vld_in     (rd_en),
        .flush      (flush),
        .vld_out    (vld_out),
        .pipe_empty (pipe_empty)
    );

    // The last pipe stage may still be set in the abort cycle; kill it so no
    // partial accumulate happens. mac_clear only fires in IDLE, where the
    // pipe is always empty, so clear and next are mutually exclusive.
    assign mac_next  = vld_out & ~flush;
    assign mac_a     = rd_data_a;
    assign mac_b     = rd_data_b;
    assign rd_addr_a = addr_a_q;
    assign rd_addr_b = addr_b_q;
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

`ifdef MAC_DOT_SEQ_PERF_EN
    logic [LEN_W+7:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]      cmd_cycles_q, cmd_cycles_d;

    // Perf counters: restart on accept, count while active, freeze on abort.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        cmd_cycles_d = cmd_cycles_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d  = {(LEN_W+8){1'b0}};
            cmd_cycles_d = 32'd1;   // the accept cycle itself counts
        end else if ((state_q != IDLE) && !abort) begin
            cmd_cycles_d = cmd_cycles_q + 32'd1;
            if ((state_q == ISSUE) && !mem_ready && (stall_cnt_q != {(LEN_W+8){1'b1}})) begin
                stall_cnt_d = stall_cnt_q + {{(LEN_W+7){1'b0}}, 1'b1};
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d  = stall_cnt_q;
            cmd_cycles_d = cmd_cycles_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= {(LEN_W+8){1'b0}};
            cmd_cycles_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            cmd_cycles_q <= cmd_cycles_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign cmd_cycles = cmd_cycles_q;
`else
    // Perf counters not built.
`endif

endmodule : mac_dot_seq
